fpga_ccff_loader: RTL and testbench
===================================

Name: fpga_ccff_loader

Overview:
Wishbone-slave configuration sequencer that streams a bitstream into the FPGA fabric's configuration chain (ccff_head/ccff_tail) from the management SoC, instead of bit-banging GPIOs.
- Buffers 32-bit words in a small FIFO.
- Generates prog_clk as a divided version of wb_clk_i and shifts a programmed number of bits LSB-first.
- Captures the bits returned on ccff_tail for readback checking.
- Sits in the user wrapper on the Wishbone bus, alongside the fabric's prog_clk/prog_reset/ccff_head inputs.

Parameters:
FIFO_DEPTH, 4, word FIFO depth (power of 2, >=2)
CLKDIV_W, 8, width of prog_clk half-period divider register

Ports:
wb_clk_i  in  1  system clock; all logic in this domain
wb_rst_i  in  1  asynchronous active-high reset
wbs_stb_i  in  1  Wishbone strobe
wbs_cyc_i  in  1  Wishbone cycle
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte selects; writes honour them (DATA ignores sel, always full word)
wbs_adr_i  in  32  address; bits [4:2] select register, others ignored
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  acknowledge
wbs_dat_o  out  32  read data
prog_clk_o  out  1  fabric configuration clock
prog_reset_o  out  1  fabric configuration reset, from CTRL[1]
ccff_head_o  out  1  serial config data into fabric
ccff_tail_i  in  1  serial config data out of fabric

Behaviour:
Reset values of outputs:
- wbs_ack_o=0, wbs_dat_o=0, prog_clk_o=0, prog_reset_o=1, ccff_head_o=0.

Bus timing:
- Ack goes high 1 cycle after stb&cyc and stays high 1 cycle only. A new access cannot be acked back-to-back without stb low or a fresh cycle.
- Read data is valid with ack.

Registers (addr[4:2]):
- 0 CTRL (RW). [0] start, write-1 pulse, reads 0. [1] prog_reset (reset value 1). [2] abort, write-1 pulse, reads 0.
- 1 STATUS (RO; W1C on [3]). [0] busy. [1] done (sticky, cleared on start). [2] fifo_empty. [3] overflow (sticky). [7:4] fifo_count.
- 2 DATA (WO). Push word into FIFO. If full: word dropped, overflow set, ack still returned.
- 3 LEN (RW, 16 bits). Total bits to shift. 0 means start sets done immediately, no pulses.
- 4 CLKDIV (RW, CLKDIV_W bits). Each prog_clk phase lasts CLKDIV+1 cycles.
- 5 TAIL (RO). Last 32 ccff_tail samples; newest bit in [31], shifted right each sample.

State machine: IDLE, FETCH, LOW, HIGH, DONE.
- IDLE: start with LEN!=0 -> FETCH. bitcnt=LEN. done cleared. busy=1 in every state except IDLE.
- FETCH: if FIFO non-empty, pop into shift reg, bitpos=0 -> LOW. If empty, stay (stall): prog_clk held 0, no error.
- LOW: on entry ccff_head_o=shreg[bitpos]; prog_clk_o=0 for CLKDIV+1 cycles -> HIGH.
- HIGH: prog_clk_o=1 for CLKDIV+1 cycles. On the first HIGH cycle, register ccff_tail_i into TAIL. On exit, bitcnt-1 and bitpos+1.
- HIGH exit branches: if bitcnt reaches 0 -> DONE; else if bitpos wraps 31->0 -> FETCH; else -> LOW.
- DONE: done=1, prog_clk_o=0, ccff_head_o held -> IDLE next cycle. Unused remaining bits of the last word are discarded.

Boundary conditions:
- Start while busy: ignored.
- Abort (any state): next cycle prog_clk_o=0, FIFO flushed, state IDLE, done unchanged.
- Abort and start in the same write: abort wins.
- FIFO push and pop in the same cycle: count unchanged.
- Async reset mid-shift: all state cleared immediately, prog_reset_o=1.

Optional Feature:
CCFF_LOADER_IRQ_EN
- Defined: adds output port irq_o (1 bit), registered, reset 0. irq_o = done & CTRL[3], where CTRL[3] is irq_enable (RW, reset 0). Cleared when done clears.
- Undefined: no irq_o port; CTRL[3] reads 0 and writes are ignored.

Test Plan:
- Reset -> prog_reset_o=1, prog_clk_o=0, STATUS=0x04, TAIL=0, CTRL reads 0x2.
- CLKDIV=0, LEN=40, push 0xA5A5A5A5 and 0x000000FF, start -> exactly 40 prog_clk pulses, period 2 cycles. ccff_head order is 32 bits of 0xA5A5A5A5 LSB-first, then 8 ones. done=1, busy=0, fifo_empty=1.
- Tie ccff_tail_i=ccff_head_o delayed by 1 pulse, LEN=32, push 0x12345678 -> TAIL=0x2468ACF0 (input shifted by one, first sample 0).
- LEN=64, push one word, start -> stall in FETCH after 32 pulses with prog_clk_o=0. Push second word -> resume; total 64 pulses, done=1.
- Push FIFO_DEPTH+1 words while idle -> overflow=1, fifo_count=4. Write STATUS[3]=1 -> overflow=0.
- Start with LEN=100, CLKDIV=3, abort after 10 pulses -> prog_clk_o=0 the following cycle, busy=0, fifo_empty=1, no further pulses.

Source files
------------

// File: rtl/fpga_ccff_loader.sv
// Wishbone-slave sequencer that shifts a buffered bitstream LSB-first into the
// fabric configuration chain. Optional macro CCFF_LOADER_IRQ_EN adds irq_o.
module fpga_ccff_loader #(
    parameter int FIFO_DEPTH = 4,
    parameter int CLKDIV_W   = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        prog_clk_o,
    output logic        prog_reset_o,
    output logic        ccff_head_o,
`ifdef CCFF_LOADER_IRQ_EN
    output logic        irq_o,
`endif
    input  logic        ccff_tail_i
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOW   = 3'd2;
    localparam logic [2:0] S_HIGH  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [2:0] R_CTRL   = 3'd0;
    localparam logic [2:0] R_STATUS = 3'd1;
    localparam logic [2:0] R_DATA   = 3'd2;
    localparam logic [2:0] R_LEN    = 3'd3;
    localparam logic [2:0] R_CLKDIV = 3'd4;
    localparam logic [2:0] R_TAIL   = 3'd5;

    logic                ack_r;
    logic [31:0]         dat_r;
    logic                prog_reset_r;
    logic [15:0]         len_r;
    logic [CLKDIV_W-1:0] clkdiv_r;
    logic                overflow_r;
    logic                done_r;
    logic [31:0]         tail_r;
    logic                irq_en_bit;

    logic [2:0]          state;
    logic [CLKDIV_W-1:0] divcnt;
    logic [15:0]         bitcnt;
    logic [4:0]          bitpos;
    logic [31:0]         shreg;
    logic                head_r;
    logic                pclk_r;

    logic [31:0]         fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [CW-1:0]       fifo_cnt;

    logic [2:0]          reg_sel;
    logic                access;
    logic                wr_en;
    logic [31:0]         wmask;
    logic [31:0]         wdat_m;
    logic                start_req;
    logic                abort_req;
    logic                push_req;
    logic                push;
    logic                pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic                busy;
    logic [3:0]          cnt4;
    logic [31:0]         rdata;
    logic                unused_adr;

    assign unused_adr = ^{wbs_adr_i[31:5], wbs_adr_i[1:0]};

    // A slave access is accepted only while ack is low, so each strobe gets one ack.
    assign access    = wbs_stb_i & wbs_cyc_i & ~ack_r;
    assign wr_en     = access & wbs_we_i;
    assign reg_sel   = wbs_adr_i[4:2];
    assign wmask     = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign wdat_m    = wbs_dat_i & wmask;
    assign start_req = wr_en && (reg_sel == R_CTRL) && wdat_m[0];
    assign abort_req = wr_en && (reg_sel == R_CTRL) && wdat_m[2];
    assign push_req  = wr_en && (reg_sel == R_DATA);

    assign fifo_full  = (fifo_cnt == CW'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign push       = push_req & ~fifo_full;
    assign pop        = (state == S_FETCH) & ~fifo_empty & ~abort_req;
    assign busy       = (state != S_IDLE);
    assign cnt4       = 4'(fifo_cnt);

    assign wbs_ack_o    = ack_r;
    assign wbs_dat_o    = dat_r;
    assign prog_clk_o   = pclk_r;
    assign prog_reset_o = prog_reset_r;
    assign ccff_head_o  = head_r;

    always_comb begin
        rdata = 32'd0;
        case (reg_sel)
            R_CTRL:   rdata = {28'd0, irq_en_bit, 1'b0, prog_reset_r, 1'b0};
            R_STATUS: rdata = {24'd0, cnt4, overflow_r, fifo_empty, done_r, busy};
            R_LEN:    rdata = {16'd0, len_r};
            R_CLKDIV: rdata = 32'(clkdiv_r);
            R_TAIL:   rdata = tail_r;
            default:  rdata = 32'd0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_r        <= 1'b0;
            dat_r        <= 32'd0;
            prog_reset_r <= 1'b1;
            len_r        <= 16'd0;
            clkdiv_r     <= '0;
            overflow_r   <= 1'b0;
        end else begin
            ack_r <= access;
            dat_r <= (access && !wbs_we_i) ? rdata : 32'd0;
            if (push_req && fifo_full)
                overflow_r <= 1'b1;
            if (wr_en) begin
                case (reg_sel)
                    R_CTRL:   if (wbs_sel_i[0]) prog_reset_r <= wbs_dat_i[1];
                    R_STATUS: if (wdat_m[3]) overflow_r <= 1'b0;
                    R_LEN: begin
                        if (wbs_sel_i[0]) len_r[7:0]  <= wbs_dat_i[7:0];
                        if (wbs_sel_i[1]) len_r[15:8] <= wbs_dat_i[15:8];
                    end
                    R_CLKDIV: begin
                        for (int i = 0; i < CLKDIV_W; i++)
                            if (wbs_sel_i[i/8]) clkdiv_r[i] <= wbs_dat_i[i];
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef CCFF_LOADER_IRQ_EN
    logic irq_en_r;
    logic irq_r;
    assign irq_en_bit = irq_en_r;
    assign irq_o      = irq_r;
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            irq_en_r <= 1'b0;
            irq_r    <= 1'b0;
        end else begin
            if (wr_en && (reg_sel == R_CTRL) && wbs_sel_i[0])
                irq_en_r <= wbs_dat_i[3];
            irq_r <= done_r & irq_en_r;
        end
    end
`else
    assign irq_en_bit = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (push)
            fifo_mem[wr_ptr] <= wbs_dat_i;
    end

    // Abort flushes the FIFO and wins over a pop issued in the same cycle.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (abort_req) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state  <= S_IDLE;
            divcnt <= '0;
            bitcnt <= 16'd0;
            bitpos <= 5'd0;
            shreg  <= 32'd0;
            head_r <= 1'b0;
            pclk_r <= 1'b0;
            tail_r <= 32'd0;
            done_r <= 1'b0;
        end else if (abort_req) begin
            state  <= S_IDLE;
            divcnt <= '0;
            pclk_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_req) begin
                        if (len_r != 16'd0) begin
                            state  <= S_FETCH;
                            bitcnt <= len_r;
                            done_r <= 1'b0;
                        end else begin
                            done_r <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    // An empty FIFO simply stalls here with prog_clk parked low.
                    if (!fifo_empty) begin
                        shreg  <= fifo_mem[rd_ptr];
                        head_r <= fifo_mem[rd_ptr][0];
                        bitpos <= 5'd0;
                        divcnt <= '0;
                        state  <= S_LOW;
                    end
                end
                S_LOW: begin
                    if (divcnt == clkdiv_r) begin
                        divcnt <= '0;
                        pclk_r <= 1'b1;
                        state  <= S_HIGH;
                    end else begin
                        divcnt <= divcnt + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (divcnt == '0)
                        tail_r <= {ccff_tail_i, tail_r[31:1]};
                    if (divcnt == clkdiv_r) begin
                        divcnt <= '0;
                        pclk_r <= 1'b0;
                        bitcnt <= bitcnt - 16'd1;
                        bitpos <= bitpos + 5'd1;
                        if (bitcnt == 16'd1) begin
                            state <= S_DONE;
                        end else if (bitpos == 5'd31) begin
                            state <= S_FETCH;
                        end else begin
                            head_r <= shreg[bitpos + 5'd1];
                            state  <= S_LOW;
                        end
                    end else begin
                        divcnt <= divcnt + 1'b1;
                    end
                end
                S_DONE: begin
                    done_r <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpga_ccff_loader.sv
// Directed self-checking bench for fpga_ccff_loader (default build, no irq_o).
module tb_fpga_ccff_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb;
    logic        cyc;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic        ack;
    logic [31:0] rdat;
    logic        prog_clk;
    logic        prog_reset;
    logic        head;
    logic        tail;

    int errors = 0;
    int checks = 0;

    int   pulse_cnt = 0;
    logic head_q [$];
    time  rise_q [$];
    logic last_head = 1'b0;
    logic delayed = 1'b0;
    logic loop_en = 1'b0;

    localparam logic [2:0] R_CTRL   = 3'd0;
    localparam logic [2:0] R_STATUS = 3'd1;
    localparam logic [2:0] R_DATA   = 3'd2;
    localparam logic [2:0] R_LEN    = 3'd3;
    localparam logic [2:0] R_CLKDIV = 3'd4;
    localparam logic [2:0] R_TAIL   = 3'd5;

    always #5 clk = ~clk;

    fpga_ccff_loader dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .wbs_stb_i    (stb),
        .wbs_cyc_i    (cyc),
        .wbs_we_i     (we),
        .wbs_sel_i    (sel),
        .wbs_adr_i    (adr),
        .wbs_dat_i    (wdat),
        .wbs_ack_o    (ack),
        .wbs_dat_o    (rdat),
        .prog_clk_o   (prog_clk),
        .prog_reset_o (prog_reset),
        .ccff_head_o  (head),
        .ccff_tail_i  (tail)
    );

    // Fabric model: record each rising prog_clk and optionally loop head back
    // to tail delayed by one pulse.
    always @(posedge prog_clk) begin
        pulse_cnt++;
        head_q.push_back(head);
        rise_q.push_back($time);
        last_head = head;
    end

    always @(negedge prog_clk) delayed = loop_en ? last_head : 1'b0;

    assign tail = loop_en ? delayed : 1'b0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic wb_xfer(input logic w, input logic [2:0] r, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] q);
        bit got;
        got = 0;
        q = 32'd0;
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = w; sel = s; adr = {27'd0, r, 2'b00}; wdat = d;
        for (int n = 0; n < 8 && !got; n++) begin
            @(posedge clk); #1;
            if (ack) begin
                got = 1;
                q = rdat;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        if (!got) begin
            errors++; checks++;
            $display("FAIL wb_ack: no ack for reg %0d, got 0 expected 1", r);
        end
    endtask

    task automatic wb_write(input logic [2:0] r, input logic [31:0] d);
        logic [31:0] q;
        wb_xfer(1'b1, r, d, 4'hF, q);
    endtask

    task automatic wb_read(input logic [2:0] r, output logic [31:0] q);
        wb_xfer(1'b0, r, 32'd0, 4'hF, q);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_pulses(input int target, input int budget);
        int n;
        n = 0;
        while (pulse_cnt < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (pulse_cnt < target) begin
            errors++; checks++;
            $display("FAIL wait_pulses: got %0d pulses expected %0d", pulse_cnt, target);
        end
    endtask

    task automatic wait_idle(input int budget);
        logic [31:0] st;
        bit idle;
        idle = 0;
        for (int n = 0; n < budget && !idle; n++) begin
            wb_read(R_STATUS, st);
            if (!st[0]) idle = 1;
        end
        if (!idle) begin
            errors++; checks++;
            $display("FAIL wait_idle: busy still 1 expected 0");
        end
    endtask

    task automatic test_reset();
        logic [31:0] q;
        rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'd0; wdat = 32'd0;
        wait_cycles(3);
        checks++;
        if ({prog_reset, prog_clk, head, ack} !== 4'b1000 || rdat !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rst=%b clk=%b head=%b ack=%b dat=%h expected 1 0 0 0 0",
                     prog_reset, prog_clk, head, ack, rdat);
        end
        rst = 1'b0;
        wait_cycles(1);
        wb_read(R_STATUS, q);
        checks++;
        if (q !== 32'h4) begin errors++; $display("FAIL reset_status: got %h expected 00000004", q); end
        wb_read(R_TAIL, q);
        checks++;
        if (q !== 32'h0) begin errors++; $display("FAIL reset_tail: got %h expected 00000000", q); end
        wb_read(R_CTRL, q);
        checks++;
        if (q !== 32'h2) begin errors++; $display("FAIL reset_ctrl: got %h expected 00000002", q); end
    endtask

    task automatic test_len_zero();
        logic [31:0] q;
        int base;
        base = pulse_cnt;
        wb_write(R_LEN, 32'd0);
        wb_write(R_CTRL, 32'h3);
        wait_cycles(4);
        wb_read(R_STATUS, q);
        checks++;
        if (q !== 32'h6 || pulse_cnt !== base) begin
            errors++;
            $display("FAIL len_zero: got status %h pulses %0d expected 00000006 and %0d", q, pulse_cnt, base);
        end
    endtask

    task automatic test_registers();
        logic [31:0] q;
        wb_write(R_LEN, 32'h0000_1234);
        wb_xfer(1'b1, R_LEN, 32'h0000_ABCD, 4'b0001, q);
        wb_read(R_LEN, q);
        checks++;
        if (q !== 32'h0000_12CD) begin errors++; $display("FAIL len_bytesel: got %h expected 000012cd", q); end
        wb_write(R_CLKDIV, 32'h0000_01FF);
        wb_read(R_CLKDIV, q);
        checks++;
        if (q !== 32'h0000_00FF) begin errors++; $display("FAIL clkdiv_width: got %h expected 000000ff", q); end
        wb_write(R_CTRL, 32'h8);
        wb_read(R_CTRL, q);
        checks++;
        if (q !== 32'h0 || prog_reset !== 1'b0) begin
            errors++;
            $display("FAIL ctrl_write: got ctrl %h prog_reset %b expected 00000000 and 0", q, prog_reset);
        end
        wb_write(R_CTRL, 32'h2);
        checks++;
        if (prog_reset !== 1'b1) begin errors++; $display("FAIL prog_reset_set: got %b expected 1", prog_reset); end
    endtask

    task automatic test_stream();
        logic [31:0] q;
        logic [39:0] got;
        int base;
        int hb;
        wb_write(R_CLKDIV, 32'd0);
        wb_write(R_LEN, 32'd40);
        wb_write(R_DATA, 32'hA5A5_A5A5);
        wb_write(R_DATA, 32'h0000_00FF);
        base = pulse_cnt;
        hb = head_q.size();
        wb_write(R_CTRL, 32'h1);
        wait_idle(200);
        checks++;
        if (pulse_cnt - base !== 40) begin
            errors++; $display("FAIL stream_pulses: got %0d expected 40", pulse_cnt - base);
        end
        got = '0;
        for (int i = 0; i < 40 && hb + i < head_q.size(); i++) got[i] = head_q[hb + i];
        checks++;
        if (got !== {8'hFF, 32'hA5A5_A5A5}) begin
            errors++; $display("FAIL stream_head: got %h expected ffa5a5a5a5", got);
        end
        checks++;
        if (rise_q.size() < hb + 2 || rise_q[hb + 1] - rise_q[hb] !== 20) begin
            errors++; $display("FAIL stream_period: first pulse period wrong, expected 20");
        end
        wb_read(R_STATUS, q);
        checks++;
        if (q !== 32'h6) begin errors++; $display("FAIL stream_status: got %h expected 00000006", q); end
    endtask

    task automatic test_loopback();
        logic [31:0] q;
        loop_en = 1'b1;
        wb_write(R_LEN, 32'd32);
        wb_write(R_DATA, 32'h1234_5678);
        wb_write(R_CTRL, 32'h1);
        wait_idle(200);
        loop_en = 1'b0;
        wb_read(R_TAIL, q);
        checks++;
        if (q !== 32'h2468_ACF0) begin errors++; $display("FAIL tail_loop: got %h expected 2468acf0", q); end
    endtask

    task automatic test_stall();
        logic [31:0] q;
        logic [31:0] w2;
        int base;
        int hb;
        wb_write(R_LEN, 32'd64);
        wb_write(R_DATA, 32'hDEAD_BEEF);
        base = pulse_cnt;
        hb = head_q.size();
        wb_write(R_CTRL, 32'h1);
        wait_pulses(base + 32, 500);
        wait_cycles(20);
        checks++;
        if (pulse_cnt - base !== 32 || prog_clk !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: got pulses %0d clk %b expected 32 and 0", pulse_cnt - base, prog_clk);
        end
        wb_read(R_STATUS, q);
        checks++;
        if (q !== 32'h5) begin errors++; $display("FAIL stall_status: got %h expected 00000005", q); end
        // A second start while busy must not reload the bit count.
        wb_write(R_CTRL, 32'h1);
        wb_write(R_DATA, 32'h0F0F_0F0F);
        wait_idle(200);
        checks++;
        if (pulse_cnt - base !== 64) begin
            errors++; $display("FAIL stall_total: got %0d pulses expected 64", pulse_cnt - base);
        end
        w2 = '0;
        for (int i = 0; i < 32 && hb + 32 + i < head_q.size(); i++) w2[i] = head_q[hb + 32 + i];
        checks++;
        if (w2 !== 32'h0F0F_0F0F) begin errors++; $display("FAIL stall_word2: got %h expected 0f0f0f0f", w2); end
        wb_read(R_STATUS, q);
        checks++;
        if (q !== 32'h6) begin errors++; $display("FAIL stall_done: got %h expected 00000006", q); end
    endtask

    task automatic test_overflow();
        logic [31:0] q;
        for (int i = 0; i < 5; i++) wb_write(R_DATA, 32'h100 + 32'(i));
        wb_read(R_STATUS, q);
        checks++;
        if (q !== 32'h4A) begin errors++; $display("FAIL overflow_set: got %h expected 0000004a", q); end
        wb_write(R_STATUS, 32'h8);
        wb_read(R_STATUS, q);
        checks++;
        if (q !== 32'h42) begin errors++; $display("FAIL overflow_clear: got %h expected 00000042", q); end
        wb_write(R_CTRL, 32'h6);
        wb_read(R_STATUS, q);
        checks++;
        if (q !== 32'h6) begin errors++; $display("FAIL idle_abort_flush: got %h expected 00000006", q); end
    endtask

    task automatic test_abort();
        logic [31:0] q;
        int base;
        wb_write(R_CLKDIV, 32'd3);
        wb_write(R_LEN, 32'd100);
        for (int i = 0; i < 4; i++) wb_write(R_DATA, 32'hFFFF_FFFF);
        base = pulse_cnt;
        wb_write(R_CTRL, 32'h1);
        wait_pulses(base + 10, 500);
        wb_write(R_CTRL, 32'h4);
        checks++;
        if (prog_clk !== 1'b0) begin errors++; $display("FAIL abort_clk: got %b expected 0", prog_clk); end
        wb_read(R_STATUS, q);
        checks++;
        if (q !== 32'h4) begin errors++; $display("FAIL abort_status: got %h expected 00000004", q); end
        wait_cycles(60);
        checks++;
        if (pulse_cnt - base !== 10) begin
            errors++; $display("FAIL abort_pulses: got %0d expected 10", pulse_cnt - base);
        end
        wb_write(R_DATA, 32'h1);
        wb_write(R_CTRL, 32'h5);
        wb_read(R_STATUS, q);
        checks++;
        if (q !== 32'h4) begin errors++; $display("FAIL abort_wins: got %h expected 00000004", q); end
    endtask

    task automatic test_async_reset();
        logic [31:0] q;
        int base;
        wb_write(R_CLKDIV, 32'd1);
        wb_write(R_LEN, 32'd32);
        wb_write(R_DATA, 32'hFFFF_FFFF);
        base = pulse_cnt;
        wb_write(R_CTRL, 32'h1);
        wait_pulses(base + 5, 500);
        #3 rst = 1'b1;
        #1;
        checks++;
        if (prog_clk !== 1'b0 || prog_reset !== 1'b1 || head !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got clk=%b prog_reset=%b head=%b expected 0 1 0", prog_clk, prog_reset, head);
        end
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(1);
        wb_read(R_STATUS, q);
        checks++;
        if (q !== 32'h4) begin errors++; $display("FAIL async_status: got %h expected 00000004", q); end
        wb_read(R_TAIL, q);
        checks++;
        if (q !== 32'h0) begin errors++; $display("FAIL async_tail: got %h expected 00000000", q); end
    endtask

    initial begin
        test_reset();
        test_len_zero();
        test_registers();
        test_stream();
        test_loopback();
        test_stall();
        test_overflow();
        test_abort();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
